// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: per-cycle stall/flush/bubble sequencer for a 5-stage pipeline.
//   inputs : clk, rst, ID operand fields (id_rs, id_rt, id_uses_rt), id_branch_taken,
//            EX load info (ex_rd, ex_mem_read), MEM handshake (mem_req, MIO_ready)
//   outputs: pipeline register enables/flush/bubble, shouldStall, mem_timeout pulse,
//            saturating stall_cnt of cycles with the PC frozen
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch_taken,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             mem_req,
  input  logic             MIO_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic             shouldStall,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, WAIT, ABORT} state_t;
  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          mem_stall, load_use, abort;
  assign abort     = state == ABORT;
  assign mem_stall = mem_req & ~MIO_ready & ~abort;
  assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                     ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
  // Memory stall freezes everything; a load-use stall only holds PC and IF/ID.
  always_comb begin
    pc_en        = rst ? 1'b0 : ~mem_stall & ~load_use;
    ifid_en      = pc_en;
    idex_en      = rst ? 1'b0 : ~mem_stall;
    exmem_en     = idex_en;
    ifid_flush   = rst ? 1'b1 : ~mem_stall & ~load_use & id_branch_taken;
    idex_bubble  = rst ? 1'b1 : ~mem_stall & load_use;
    memwb_bubble = rst | mem_stall | abort;
    mem_timeout  = ~rst & abort;
    shouldStall  = ~pc_en;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      case (state)
        IDLE: if (mem_req && !MIO_ready) begin
          state    <= WAIT;
          wait_cnt <= WW'(1);
        end
        WAIT: if (MIO_ready || !mem_req) begin
          state    <= IDLE;
          wait_cnt <= '0;
        end else if (wait_cnt == WW'(TIMEOUT - 1)) state <= ABORT;
        else wait_cnt <= wait_cnt + 1'b1;
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed plan scenarios plus random traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic id_uses_rt = 1'b0, id_branch_taken = 1'b0, ex_mem_read = 1'b0, mem_req = 1'b0, MIO_ready = 1'b0;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble, shouldStall, mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  int total = 0, bad = 0, timeouts = 0;
  int m_run = 0;
  bit m_abort = 1'b0, m_cnt_ok = 1'b0;
  longint m_cnt = 0;
  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_branch_taken(id_branch_taken), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .mem_req(mem_req), .MIO_ready(MIO_ready), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_bubble(idex_bubble),
    .exmem_en(exmem_en), .memwb_bubble(memwb_bubble), .shouldStall(shouldStall),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  // order: pc_en ifid_en ifid_flush idex_en idex_bubble exmem_en memwb_bubble mem_timeout shouldStall
  task automatic cyc(input bit r, input bit req, input bit rdy, input bit lr, input bit [4:0] rd,
                     input bit [4:0] rs, input bit [4:0] rt, input bit urt, input bit br);
    bit ms, lu, pc, fe, ff, de, db, me, wb, to;
    rst = r; mem_req = req; MIO_ready = rdy; ex_mem_read = lr; ex_rd = rd;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; id_branch_taken = br;
    #3;
    ms = req && !rdy && !m_abort;
    lu = lr && rd != 0 && (rd == rs || (urt && rd == rt));
    if (r) {pc, fe, ff, de, db, me, wb, to} = 8'b00101010;
    else if (ms) {pc, fe, ff, de, db, me, wb, to} = 8'b00000010;
    else begin
      {pc, fe, ff, de, db, me, wb, to} = {6'b110101, m_abort, m_abort};
      if (lu) begin pc = 0; fe = 0; db = 1; end
      else if (br) ff = 1;
    end
    chk("ctl", {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble, mem_timeout, shouldStall},
        {pc, fe, ff, de, db, me, wb, to, !pc});
    if (m_cnt_ok) chk("stall_cnt", stall_cnt, m_cnt);
    if (mem_timeout) timeouts++;
    @(posedge clk);
    #1;
    if (r) begin
      m_run = 0; m_abort = 0; m_cnt = 0; m_cnt_ok = 1;
    end else begin
      if (!pc && m_cnt < (64'd1 << CNT_W) - 1) m_cnt++;
      if (m_abort) begin m_abort = 0; m_run = 0; end
      else if (ms) begin
        m_run++;
        if (m_run == TIMEOUT) begin m_abort = 1; m_run = 0; end
      end else m_run = 0;
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    #1;
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_cnt", stall_cnt, 0);
    idle(2);
    cyc(0, 0, 0, 1, 3, 3, 7, 1, 0);
    chk("lu_cnt", stall_cnt, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 5, 1, 5, 0, 0);
    cyc(0, 0, 0, 1, 5, 1, 5, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("mem_wait_cnt", stall_cnt, 3);
    chk("no_timeout", timeouts, 0);
    for (int i = 0; i < TIMEOUT + 1; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("timeout_pulses", timeouts, 1);
    idle(1);
    cyc(0, 0, 0, 1, 4, 4, 0, 0, 1);
    cyc(0, 0, 0, 0, 4, 4, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT; i++) cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_wait_no_to", timeouts, 1);
    for (int b = 0; b < 40; b++) begin
      int p = $urandom_range(0, 3);
      for (int i = 0; i < 40; i++)
        cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
            p == 0 ? 1'b0 : $urandom_range(0, 3) < p,
            $urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 3) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
